// File: rtl/psum_pkg.sv
// Shared definitions for the psum input unpacker: default stream width,
// pointer width helper, slot record layout and the bit-count clamp.
package psum_pkg;

    localparam int C_S_AXIS_TDATA_WIDTH = 32;

    // Number of bits needed to represent value (clogb2(31) = 5)
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((value >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

    localparam int PTR_W = clogb2(C_S_AXIS_TDATA_WIDTH - 1);

    // Slot contents at the default width; nbits holds 1..W
    typedef struct packed {
        logic [C_S_AXIS_TDATA_WIDTH-1:0] word;
        logic                            valid;
        logic                            last;
        logic [6:0]                      nbits;
    } slot_t;

    // Valid bit count of a tlast word: 0 or anything above the width means a full word
    function automatic logic [6:0] clamp_nbits(input logic [5:0] lwb, input logic [6:0] width);
        if (lwb == 6'd0 || {1'b0, lwb} > width) return width;
        return {1'b0, lwb};
    endfunction

endpackage

// File: rtl/psum_unpack_slot.sv
// One storage slot of the unpacker: {word, valid, last, nbits}.
// Load has priority over clear; reset only invalidates the slot.
module psum_unpack_slot
    import psum_pkg::*;
#(
    parameter int W = C_S_AXIS_TDATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_word,
    input  logic         i_last,
    input  logic [6:0]   i_nbits,
    output logic [W-1:0] o_word,
    output logic         o_valid,
    output logic         o_last,
    output logic [6:0]   o_nbits
);

    logic [W-1:0] r_word;
    logic         r_valid;
    logic         r_last;
    logic [6:0]   r_nbits;

    // Occupancy flag: the only state that needs a reset
    always_ff @(posedge clk) begin
        if (rst)          r_valid <= 1'b0;
        else if (i_load)  r_valid <= 1'b1;
        else if (i_clear) r_valid <= 1'b0;
    end

    // Payload captured on load only; meaningless while the slot is empty
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_word  <= i_word;
            r_last  <= i_last;
            r_nbits <= i_nbits;
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_nbits = r_nbits;

endmodule

// File: rtl/psum_in_data_unpackage.sv
// AXI4-Stream slave that serialises psum words LSB first, one bit per cycle.
// Two slots (CUR shifting, NXT waiting) give gap-free back-to-back streaming.
// Optional feature macro: PSUM_UNPACK_BITCNT_EN adds the bit_count output.
module psum_in_data_unpackage
    import psum_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = psum_pkg::C_S_AXIS_TDATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [5:0]                      last_word_bits,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_data,
    output logic                            out_last
`ifdef PSUM_UNPACK_BITCNT_EN
    ,
    output logic [31:0]                     bit_count
`endif
);

    localparam int W      = C_S_AXIS_TDATA_WIDTH;
    localparam int LPTR_W = clogb2(W - 1);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [LPTR_W-1:0] r_ptr;
    logic [1:0]        w_state;

    logic [W-1:0] w_cur_word, w_nxt_word, w_cur_in_word;
    logic         w_cur_valid, w_nxt_valid, w_cur_last, w_nxt_last, w_cur_in_last;
    logic [6:0]   w_cur_nbits, w_nxt_nbits, w_cur_in_nbits, w_in_nbits;

    logic w_accept, w_xfer, w_at_end, w_cur_done;
    logic w_cur_load, w_cur_from_nxt, w_cur_clear, w_nxt_load;

    // Occupancy state, derived purely from the slot valid flags
    always_comb begin
        w_state = S_EMPTY;
        if (w_nxt_valid)      w_state = S_FULL;
        else if (w_cur_valid) w_state = S_ONE;
    end

    assign s_axis_tready = !rst && (w_state != S_FULL);
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_in_nbits    = s_axis_tlast ? clamp_nbits(last_word_bits, 7'(W)) : 7'(W);

    assign w_xfer     = w_cur_valid && out_ready;
    assign w_at_end   = ({{(7-LPTR_W){1'b0}}, r_ptr} == (w_cur_nbits - 7'd1));
    assign w_cur_done = w_xfer && w_at_end;

    // CUR refills from NXT first; the input only goes straight to CUR when NXT is empty
    assign w_cur_from_nxt = w_cur_done && w_nxt_valid;
    assign w_cur_load     = w_cur_from_nxt || (w_accept && (!w_cur_valid || w_cur_done));
    assign w_cur_clear    = w_cur_done;
    assign w_nxt_load     = w_accept && w_cur_valid && !w_cur_done;

    assign w_cur_in_word  = w_cur_from_nxt ? w_nxt_word  : s_axis_tdata;
    assign w_cur_in_last  = w_cur_from_nxt ? w_nxt_last  : s_axis_tlast;
    assign w_cur_in_nbits = w_cur_from_nxt ? w_nxt_nbits : w_in_nbits;

    psum_unpack_slot #(.W(W)) u_cur (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_cur_load),
        .i_clear (w_cur_clear),
        .i_word  (w_cur_in_word),
        .i_last  (w_cur_in_last),
        .i_nbits (w_cur_in_nbits),
        .o_word  (w_cur_word),
        .o_valid (w_cur_valid),
        .o_last  (w_cur_last),
        .o_nbits (w_cur_nbits)
    );

    psum_unpack_slot #(.W(W)) u_nxt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_nxt_load),
        .i_clear (w_cur_from_nxt),
        .i_word  (s_axis_tdata),
        .i_last  (s_axis_tlast),
        .i_nbits (w_in_nbits),
        .o_word  (w_nxt_word),
        .o_valid (w_nxt_valid),
        .o_last  (w_nxt_last),
        .o_nbits (w_nxt_nbits)
    );

    // Bit pointer into CUR: advances per transfer, wraps at the word's final bit
    always_ff @(posedge clk) begin
        if (rst)             r_ptr <= '0;
        else if (w_cur_done) r_ptr <= '0;
        else if (w_xfer)     r_ptr <= r_ptr + 1'b1;
    end

    assign out_valid = w_cur_valid;
    assign out_data  = w_cur_valid && w_cur_word[r_ptr];
    assign out_last  = w_cur_valid && w_cur_last && w_at_end;

`ifdef PSUM_UNPACK_BITCNT_EN
    logic [31:0] r_bit_count;

    // Transfers completed since reset or since the last out_last transfer
    always_ff @(posedge clk) begin
        if (rst)                       r_bit_count <= '0;
        else if (w_xfer && out_last)   r_bit_count <= '0;
        else if (w_xfer && r_bit_count != 32'hFFFF_FFFF) r_bit_count <= r_bit_count + 32'd1;
    end

    // Includes the transfer happening this cycle, saturating at all-ones
    assign bit_count = (w_xfer && r_bit_count != 32'hFFFF_FFFF) ? r_bit_count + 32'd1 : r_bit_count;
`endif

endmodule

// File: tb/tb_psum_in_data_unpackage.sv
// Self-checking bench for psum_in_data_unpackage: directed scenarios followed
// by randomized traffic, all checked against a queue-of-bits reference model.
module tb_psum_in_data_unpackage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  last_word_bits;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        out_valid;
    logic        out_ready;
    logic        out_data;
    logic        out_last;
`ifdef PSUM_UNPACK_BITCNT_EN
    logic [31:0] bit_count;
    int unsigned mcnt;
`endif

    always #5 clk = ~clk;

    psum_in_data_unpackage dut (
        .clk            (clk),
        .rst            (rst),
        .last_word_bits (last_word_bits),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last)
`ifdef PSUM_UNPACK_BITCNT_EN
        ,
        .bit_count      (bit_count)
`endif
    );

    // Model: every pending output bit in order, tagged with layer-last and word-end
    typedef struct {
        logic b;
        logic l;
        logic e;
    } mbit_t;
    mbit_t q[$];

    int checks = 0;
    int errors = 0;
    logic acc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int words_held();
        int n = 0;
        foreach (q[i]) if (q[i].e) n++;
        return n;
    endfunction

    // One clock: check outputs at negedge, advance the model at posedge, drive after
    task automatic step();
        logic exp_v, exp_rdy;
        int   nb;
        @(negedge clk);
        exp_v   = (q.size() > 0);
        exp_rdy = !rst && (words_held() < 2);
        check("out_valid", out_valid, exp_v);
        check("tready", s_axis_tready, exp_rdy);
        if (exp_v) begin
            check("out_data", out_data, q[0].b);
            check("out_last", out_last, q[0].l);
        end else begin
            check("out_data_idle", out_data, 0);
            check("out_last_idle", out_last, 0);
        end
`ifdef PSUM_UNPACK_BITCNT_EN
        check("bit_count", bit_count, (exp_v && out_ready && mcnt != 32'hFFFF_FFFF) ? mcnt + 1 : mcnt);
`endif
        acc = 1'b0;
        @(posedge clk);
        if (rst) begin
            q.delete();
`ifdef PSUM_UNPACK_BITCNT_EN
            mcnt = 0;
`endif
        end else begin
            if (exp_v && out_ready) begin
`ifdef PSUM_UNPACK_BITCNT_EN
                if (q[0].l) mcnt = 0;
                else if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
`endif
                void'(q.pop_front());
            end
            if (s_axis_tvalid && exp_rdy) begin
                acc = 1'b1;
                nb = 32;
                if (s_axis_tlast && last_word_bits >= 1 && last_word_bits <= 32) nb = last_word_bits;
                for (int i = 0; i < nb; i++)
                    q.push_back('{b: s_axis_tdata[i], l: s_axis_tlast && (i == nb - 1), e: (i == nb - 1)});
            end
        end
        #1;
    endtask

    // Hold tvalid until the model sees the word accepted, with a cycle budget
    task automatic send(input logic [31:0] d, input logic tl, input logic [5:0] lwb);
        int n = 0;
        s_axis_tdata   = d;
        s_axis_tlast   = tl;
        last_word_bits = lwb;
        s_axis_tvalid  = 1'b1;
        do begin
            step();
            n++;
        end while (!acc && n < 200);
        check("accept_timeout", acc, 1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        last_word_bits = 6'd0; out_ready = 1'b1;
`ifdef PSUM_UNPACK_BITCNT_EN
        mcnt = 0;
`endif
        #1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // single full word, LSB first
        send(32'hA5A5_0F0F, 1'b0, 6'd0);
        idle(34);

        // two back-to-back words
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_axis_tdata = 32'h1234_5678; step();
        s_axis_tdata = 32'hDEAD_BEEF; step();
        s_axis_tvalid = 1'b0;
        idle(66);

        // partial tlast word of 3 bits
        send(32'h0000_0005, 1'b1, 6'd3);
        idle(5);

        // one-bit tlast word and an over-range count treated as full
        send(32'hFFFF_FFFF, 1'b1, 6'd1);
        idle(3);
        send(32'h8000_0001, 1'b1, 6'd40);
        idle(34);
        send(32'h7000_0001, 1'b1, 6'd0);
        idle(34);

        // stalls mid-word
        send(32'hC3C3_9696, 1'b0, 6'd0);
        idle(4);
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        out_ready = 1'b1;
        idle(20);

        // tlast word parked in NXT behind a shifting word, then reset mid-word
        send(32'h0F0F_F0F0, 1'b0, 6'd0);
        send(32'h0000_00FF, 1'b1, 6'd4);
        idle(16);
        rst = 1'b1; step();
        rst = 1'b0; step();
        send(32'h0000_0001, 1'b0, 6'd0);
        idle(34);

        // two full words then a 5-bit tlast word
        send(32'hAAAA_AAAA, 1'b0, 6'd0);
        send(32'h5555_5555, 1'b0, 6'd0);
        send(32'h0000_0015, 1'b1, 6'd5);
        idle(70);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            s_axis_tvalid  = ($urandom_range(0, 3) != 0);
            s_axis_tdata   = $urandom;
            s_axis_tlast   = ($urandom_range(0, 3) == 0);
            last_word_bits = 6'($urandom_range(0, 63));
            out_ready      = ($urandom_range(0, 4) != 0);
            rst            = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; s_axis_tvalid = 1'b0; out_ready = 1'b1;
        idle(80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
